// File: rtl/fast_pkg.sv
// rtl/fast_pkg.sv - shared FAST constants and encoder state type
package fast_pkg;

    localparam int FAST_BEAT_WIDTH   = 64;
    localparam int FAST_FIELD_W      = 64;
    localparam int BEAT_BYTES        = FAST_BEAT_WIDTH / 8;
    localparam int MAX_STOPBIT_BYTES = (FAST_FIELD_W + 6) / 7;
    localparam logic [7:0] STOP_BIT  = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        ENC_ID,
        ENC_FIELD,
        DRAIN
    } enc_state_t;

endpackage

// File: rtl/fast_stopbit_len.sv
// rtl/fast_stopbit_len.sv - stop-bit byte count of a value via leading-one detection
module fast_stopbit_len #(
    parameter int W = 64
) (
    input  logic [W-1:0] value,
    output logic [3:0]   nbytes
);

    // Highest set bit wins; zero still needs one byte.
    always_comb begin
        nbytes = 4'd1;
        for (int i = 0; i < W; i++) begin
            if (value[i]) nbytes = 4'(i / 7 + 1);
        end
    end

endmodule

// File: rtl/fast_msg_encoder.sv
// rtl/fast_msg_encoder.sv - stop-bit encodes ID plus fields and packs bytes into stream beats
module fast_msg_encoder
    import fast_pkg::*;
#(
    parameter int BEAT_WIDTH = FAST_BEAT_WIDTH,
    parameter int MAX_FIELDS = 10,
    parameter int FIELD_W    = FAST_FIELD_W,
    parameter int MSGID_W    = 21,
    localparam int NB        = BEAT_WIDTH / 8,
    localparam int NFW       = $clog2(MAX_FIELDS + 1),
    localparam int CW        = $clog2(NB + 1)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          msg_valid,
    output logic                          msg_ready,
    input  logic [MSGID_W-1:0]            msg_id,
    input  logic [NFW-1:0]                msg_nfields,
    input  logic [MAX_FIELDS*FIELD_W-1:0] msg_fields,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BEAT_WIDTH-1:0]         out_data,
    output logic [CW-1:0]                 out_bytes,
    output logic                          out_last,
    output logic                          busy
);

    enc_state_t state, state_nx;

    logic [MSGID_W-1:0]            id_r;
    logic [MAX_FIELDS*FIELD_W-1:0] fields_r;
    logic [NFW-1:0]                nf_r;
    logic [NFW-1:0]                field_idx;
    logic [3:0]                    byte_idx;
    logic [BEAT_WIDTH-1:0]         pack_data;
    logic [CW-1:0]                 pack_cnt;

    logic [FIELD_W-1:0]    cur_val;
    logic [FIELD_W-1:0]    cur_shift;
    logic [3:0]            cur_nbytes;
    logic [7:0]            sel;
    logic [7:0]            enc_byte;
    logic                  stall, append, val_done, msg_final, emit, beat_retire;
    logic [BEAT_WIDTH-1:0] new_pack;
    logic [CW-1:0]         new_cnt;

    assign cur_val = (state == ENC_ID) ? FIELD_W'(id_r)
                                       : fields_r[field_idx*FIELD_W +: FIELD_W];

    fast_stopbit_len #(.W(FIELD_W)) u_len (
        .value  (cur_val),
        .nbytes (cur_nbytes)
    );

    assign stall       = out_valid && !out_ready;
    assign append      = (state == ENC_ID || state == ENC_FIELD) && !stall;
    assign beat_retire = out_valid && out_ready;
    assign val_done    = (byte_idx == cur_nbytes - 4'd1);
    assign msg_final   = val_done && ((state == ENC_ID) ? (nf_r == '0)
                                                        : (field_idx == NFW'(nf_r - 1'b1)));

    // Most-significant 7-bit group first; the stop bit marks the value's last byte.
    assign sel       = 8'(cur_nbytes - 4'd1 - byte_idx) * 8'd7;
    assign cur_shift = cur_val >> sel;
    assign enc_byte  = {1'b0, cur_shift[6:0]} | (val_done ? STOP_BIT : 8'h00);

    assign new_pack = pack_data | ({enc_byte, {(BEAT_WIDTH-8){1'b0}}} >> {pack_cnt, 3'b000});
    assign new_cnt  = pack_cnt + 1'b1;
    assign emit     = append && ((new_cnt == CW'(NB)) || msg_final);

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (msg_valid && msg_ready) state_nx = ENC_ID;
            ENC_ID:    if (append && val_done) state_nx = (nf_r == '0) ? DRAIN : ENC_FIELD;
            ENC_FIELD: if (append && msg_final) state_nx = DRAIN;
            DRAIN:     if (beat_retire && out_last) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        msg_ready = (state == IDLE) && rstn;
        busy      = (state != IDLE) || out_valid;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            id_r      <= '0;
            fields_r  <= '0;
            nf_r      <= '0;
            field_idx <= '0;
            byte_idx  <= '0;
            pack_data <= '0;
            pack_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bytes <= '0;
            out_last  <= 1'b0;
        end else begin
            if (state == IDLE && msg_valid) begin
                id_r      <= msg_id;
                fields_r  <= msg_fields;
                nf_r      <= (msg_nfields > NFW'(MAX_FIELDS)) ? NFW'(MAX_FIELDS) : msg_nfields;
                field_idx <= '0;
                byte_idx  <= '0;
            end
            if (beat_retire) out_valid <= 1'b0;
            if (append) begin
                if (val_done) begin
                    byte_idx <= '0;
                    if (state == ENC_FIELD) field_idx <= field_idx + 1'b1;
                end else begin
                    byte_idx <= byte_idx + 4'd1;
                end
                // A retiring beat and a new byte share the edge, so packing restarts at byte 0.
                if (emit) begin
                    out_valid <= 1'b1;
                    out_data  <= new_pack;
                    out_bytes <= new_cnt;
                    out_last  <= msg_final;
                    pack_data <= '0;
                    pack_cnt  <= '0;
                end else begin
                    pack_data <= new_pack;
                    pack_cnt  <= new_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_fast_msg_encoder.sv
// tb/tb_fast_msg_encoder.sv - scoreboard bench for fast_msg_encoder
module tb_fast_msg_encoder;

    localparam int BW  = 64;
    localparam int MF  = 10;
    localparam int FW  = 64;
    localparam int IW  = 21;
    localparam int NFW = 4;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic msg_valid = 1'b0;
    logic msg_ready;
    logic [IW-1:0] msg_id = '0;
    logic [NFW-1:0] msg_nfields = '0;
    logic [MF*FW-1:0] msg_fields = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [BW-1:0] out_data;
    logic [CW-1:0] out_bytes;
    logic out_last;
    logic busy;

    always #5 clk = ~clk;

    fast_msg_encoder dut (
        .clk         (clk),
        .rstn        (rstn),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready),
        .msg_id      (msg_id),
        .msg_nfields (msg_nfields),
        .msg_fields  (msg_fields),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_bytes   (out_bytes),
        .out_last    (out_last),
        .busy        (busy)
    );

    typedef struct {
        logic [BW-1:0] data;
        logic [CW-1:0] bytes;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic push_beat(input logic [BW-1:0] d, input logic [CW-1:0] n, input logic l);
        beat_t b;
        b.data = d; b.bytes = n; b.last = l;
        sb.push_back(b);
    endtask

    // Reference: build groups LSB-first then reverse, pack bytes into beats.
    task automatic push_model(input logic [IW-1:0] id, input int nfields, input logic [MF*FW-1:0] f);
        logic [7:0] bq[$];
        logic [7:0] grp[$];
        logic [FW-1:0] tmp;
        beat_t b;
        int nf;
        nf = (nfields > MF) ? MF : nfields;
        for (int v = 0; v <= nf; v++) begin
            tmp = (v == 0) ? FW'(id) : f[(v-1)*FW +: FW];
            grp.delete();
            grp.push_front({1'b1, tmp[6:0]});
            tmp = tmp >> 7;
            while (tmp != 0) begin
                grp.push_front({1'b0, tmp[6:0]});
                tmp = tmp >> 7;
            end
            foreach (grp[k]) bq.push_back(grp[k]);
        end
        b.data = '0; b.bytes = '0; b.last = 1'b0;
        for (int k = 0; k < bq.size(); k++) begin
            b.data[BW-1-8*int'(b.bytes) -: 8] = bq[k];
            b.bytes = b.bytes + 1'b1;
            if (b.bytes == 4'd8 || k == bq.size() - 1) begin
                b.last = (k == bq.size() - 1);
                sb.push_back(b);
                b.data = '0; b.bytes = '0;
            end
        end
    endtask

    task automatic offer(input logic [IW-1:0] id, input logic [NFW-1:0] nf, input logic [MF*FW-1:0] f);
        int cyc = 0;
        @(negedge clk);
        msg_valid = 1'b1; msg_id = id; msg_nfields = nf; msg_fields = f;
        while (!msg_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (msg_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: msg_ready=%b required 1", msg_ready);
        end
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        msg_id = IW'($urandom);
        msg_nfields = NFW'($urandom);
        msg_fields = {20{$urandom}};
    endtask

    task automatic collect(input int budget, input int stall_cyc, input bit rnd);
        int cyc = 0;
        bit stall_done;
        beat_t exp;
        logic [BW+CW:0] held;
        stall_done = (stall_cyc == 0);
        while (sb.size() != 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && !stall_done) begin
                stall_done = 1'b1;
                out_ready = 1'b0;
                held = {out_data, out_bytes, out_last};
                repeat (stall_cyc) begin
                    @(negedge clk);
                    checks++;
                    if ({out_valid, out_data, out_bytes, out_last} !== {1'b1, held}) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b %h/%0d/%b required v=1 %h", out_valid, out_data, out_bytes, out_last, held);
                    end
                    checks++;
                    if (msg_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_msg_ready: got %b required 0", msg_ready);
                    end
                end
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                exp = sb.pop_front();
                checks++;
                if ({out_data, out_bytes, out_last} !== {exp.data, exp.bytes, exp.last}) begin
                    errors++;
                    $display("FAIL beat: got %h bytes=%0d last=%b required %h bytes=%0d last=%b",
                             out_data, out_bytes, out_last, exp.data, exp.bytes, exp.last);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL beat_timeout: %0d beats outstanding, required 0", sb.size());
            sb.delete();
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; msg_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({msg_ready, out_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_low: ready/valid/busy=%b required 000", {msg_ready, out_valid, busy});
        end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({msg_ready, out_valid, out_last, busy} !== 4'b1000 || out_data !== '0 || out_bytes !== '0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b last=%b busy=%b data=%h bytes=%0d required 1 0 0 0 0 0",
                     msg_ready, out_valid, out_last, busy, out_data, out_bytes);
        end
    endtask

    task automatic test_single_beat;
        logic [MF*FW-1:0] f;
        f = '0;
        offer(21'd5, 4'd1, f);
        push_beat(64'h8580_0000_0000_0000, 4'd2, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid=%b required 0 one cycle after accept", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: out_valid=%b required 1 two cycles after accept", out_valid);
        end
        collect(20, 0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({msg_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL idle_return: ready/busy=%b required 10", {msg_ready, busy});
        end
        f[63:0] = 64'd300;
        offer(21'd0, 4'd1, f);
        push_beat(64'h8002_AC00_0000_0000, 4'd3, 1'b1);
        collect(20, 0, 1'b0);
    endtask

    task automatic test_multi_beat(input int stall_cyc);
        logic [MF*FW-1:0] f;
        f = '0;
        f[63:0] = '1;
        offer(21'd1, 4'd1, f);
        push_beat(64'h8101_7F7F_7F7F_7F7F, 4'd8, 1'b0);
        push_beat(64'h7F7F_FF00_0000_0000, 4'd3, 1'b1);
        collect(60, stall_cyc, 1'b0);
    endtask

    task automatic test_back_to_back;
        int cyc = 0;
        int acc = 0;
        int acc_cyc[2];
        beat_t exp;
        @(negedge clk);
        msg_valid = 1'b1; msg_id = 21'h1FFFFF; msg_nfields = 4'd0;
        push_beat(64'h7F7F_FF00_0000_0000, 4'd3, 1'b1);
        push_beat(64'h7F7F_FF00_0000_0000, 4'd3, 1'b1);
        while ((acc < 2 || sb.size() != 0) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready && sb.size() != 0) begin
                exp = sb.pop_front();
                checks++;
                if ({out_data, out_bytes, out_last} !== {exp.data, exp.bytes, exp.last}) begin
                    errors++;
                    $display("FAIL b2b_beat: got %h bytes=%0d last=%b required %h bytes=%0d last=%b",
                             out_data, out_bytes, out_last, exp.data, exp.bytes, exp.last);
                end
            end
            if (msg_valid && msg_ready) begin
                acc_cyc[acc] = cyc;
                acc++;
                if (acc == 2) begin
                    @(posedge clk); #1;
                    msg_valid = 1'b0;
                end
            end
        end
        checks++;
        if (acc != 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_done: accepts=%0d outstanding=%0d required 2 and 0", acc, sb.size());
            sb.delete();
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] != 5) begin
                errors++;
                $display("FAIL b2b_gap: got %0d cycles required 5", acc_cyc[1] - acc_cyc[0]);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_extra_beat: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_model;
        logic [MF*FW-1:0] f;
        f = '0;
        f[63:0] = 64'h0000_03FF_FFFF_FFFF;
        offer(21'h80, 4'd1, f);
        push_model(21'h80, 1, f);
        collect(100, 0, 1'b0);
        for (int m = 0; m < 6; m++) begin
            int nf;
            logic [IW-1:0] id;
            for (int i = 0; i < MF; i++) f[i*FW +: FW] = {$urandom, $urandom} >> $urandom_range(0, 63);
            nf = (m == 0) ? 15 : (m == 1) ? 0 : $urandom_range(0, 12);
            id = IW'($urandom) >> $urandom_range(0, 20);
            offer(id, NFW'(nf), f);
            push_model(id, nf, f);
            collect(400, 0, 1'b1);
        end
    endtask

    task automatic test_reset_mid;
        logic [MF*FW-1:0] f;
        f = '0;
        f[63:0] = '1;
        offer(21'd1, 4'd1, f);
        repeat (2) @(posedge clk);
        @(negedge clk); rstn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, busy, msg_ready} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset: valid/busy/ready=%b required 000", {out_valid, busy, msg_ready});
        end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (msg_ready !== 1'b1 || out_bytes !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL mid_reset_release: ready=%b bytes=%0d data=%h required 1 0 0", msg_ready, out_bytes, out_data);
        end
        f[63:0] = '0;
        offer(21'd5, 4'd1, f);
        push_beat(64'h8580_0000_0000_0000, 4'd2, 1'b1);
        collect(20, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat(0);
        test_multi_beat(5);
        test_back_to_back();
        test_model();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
